// File: rtl/leaf_out_arbiter.sv
// Leaf output arbiter: one-entry hold per user port, round-robin injection into the BFT.
// Define LEAF_OUT_CREDIT_EN to enable per-port credit flow control.
module leaf_out_arbiter #(
   parameter int PAYLOAD_BITS  = 32,
   parameter int NUM_LEAF_BITS = 5,
   parameter int NUM_PORT_BITS = 4,
   parameter int NUM_ADDR_BITS = 7,
   parameter int NUM_OUT_PORTS = 5,
   parameter int CREDIT_BITS   = 8,
   parameter int CREDIT_INIT   = 64,
   localparam int PACKET_BITS  = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS
) (
   input  logic                                               clk,
   input  logic                                               reset,
   input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]              din_leaf_user2interface,
   input  logic [NUM_OUT_PORTS-1:0]                           vld_user2interface,
   output logic [NUM_OUT_PORTS-1:0]                           ack_interface2user,
   input  logic [NUM_OUT_PORTS*(NUM_LEAF_BITS+NUM_PORT_BITS)-1:0] dest_cfg,
   input  logic                                               credit_ret_vld,
   input  logic [NUM_PORT_BITS-1:0]                           credit_ret_port,
   input  logic [CREDIT_BITS-1:0]                             credit_ret_amt,
   input  logic                                               bft_rdy,
   input  logic                                               resend,
   output logic [PACKET_BITS-1:0]                             dout_leaf_interface2bft
);

   localparam int DEST_BITS = NUM_LEAF_BITS + NUM_PORT_BITS;
   localparam int PTR_BITS  = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;

   logic [NUM_OUT_PORTS-1:0] hold_vld_q;
   logic [PAYLOAD_BITS-1:0]  hold_pay_q [NUM_OUT_PORTS];
   logic [NUM_ADDR_BITS-1:0] seq_q [NUM_OUT_PORTS];
   logic [PTR_BITS-1:0]      rr_q;
   logic [PACKET_BITS-1:0]   dout_q, dout_d;

   logic [NUM_OUT_PORTS-1:0] credit_ok, elig, grant;
   logic                     gnt_any;
   logic [PTR_BITS-1:0]      gnt_idx, idx;

   // Search starts one past the last granted port so every port gets a turn.
   always_comb begin
      grant   = '0;
      gnt_any = 1'b0;
      gnt_idx = rr_q;
      idx     = rr_q;
      elig    = hold_vld_q & credit_ok;
      if (bft_rdy && !resend) begin
         for (int k = 1; k <= NUM_OUT_PORTS; k++) begin
            idx = PTR_BITS'((int'(rr_q) + k) % NUM_OUT_PORTS);
            if (!gnt_any && elig[idx]) begin
               gnt_any = 1'b1;
               gnt_idx = idx;
            end
         end
      end
      if (gnt_any) begin
         grant[gnt_idx] = 1'b1;
      end
   end

   always_comb begin
      dout_d = '0;
      if (gnt_any) begin
         dout_d = {1'b1, dest_cfg[gnt_idx*DEST_BITS +: DEST_BITS], seq_q[gnt_idx],
                   hold_pay_q[gnt_idx]};
      end
   end

   assign ack_interface2user      = ~hold_vld_q | grant;
   assign dout_leaf_interface2bft = dout_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_vld_q <= '0;
         rr_q       <= PTR_BITS'(NUM_OUT_PORTS - 1);
         dout_q     <= '0;
         for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            hold_pay_q[i] <= '0;
            seq_q[i]      <= '0;
         end
      end else begin
         dout_q <= dout_d;
         if (gnt_any) begin
            rr_q <= gnt_idx;
         end
         for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            // A reload on the granting edge replaces the entry without a bubble.
            if (vld_user2interface[i] && ack_interface2user[i]) begin
               hold_vld_q[i] <= 1'b1;
               hold_pay_q[i] <= din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            end else if (grant[i]) begin
               hold_vld_q[i] <= 1'b0;
            end
            if (grant[i]) begin
               seq_q[i] <= seq_q[i] + NUM_ADDR_BITS'(1);
            end
         end
      end
   end

`ifdef LEAF_OUT_CREDIT_EN
   logic [CREDIT_BITS-1:0] credit_q [NUM_OUT_PORTS];
   logic [CREDIT_BITS-1:0] credit_d [NUM_OUT_PORTS];
   logic [CREDIT_BITS:0]   credit_sum;

   always_comb begin
      credit_ok = '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
         credit_ok[i] = (credit_q[i] != '0);
      end
   end

   // Extra bit catches overflow; decrement never underflows since grant needs credit.
   always_comb begin
      credit_sum = '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
         credit_sum = {1'b0, credit_q[i]};
         if (credit_ret_vld && int'(credit_ret_port) == i) begin
            credit_sum = credit_sum + {1'b0, credit_ret_amt};
         end
         if (grant[i]) begin
            credit_sum = credit_sum - (CREDIT_BITS+1)'(1);
         end
         credit_d[i] = credit_sum[CREDIT_BITS] ? '1 : credit_sum[CREDIT_BITS-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            credit_q[i] <= CREDIT_BITS'(CREDIT_INIT);
         end
      end else begin
         for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            credit_q[i] <= credit_d[i];
         end
      end
   end
`else
   logic unused_credit;
   assign credit_ok     = '1;
   assign unused_credit = ^{credit_ret_vld, credit_ret_port, credit_ret_amt,
                            CREDIT_BITS'(CREDIT_INIT)};
`endif

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Directed bench for leaf_out_arbiter; packets are checked against a scoreboard queue.
// Credit scenarios are exercised when LEAF_OUT_CREDIT_EN is defined.
module tb_leaf_out_arbiter;

   localparam int P  = 32;
   localparam int L  = 5;
   localparam int PT = 4;
   localparam int A  = 7;
   localparam int N  = 5;
   localparam int CB = 8;
   localparam int PB = 1 + L + PT + A + P;
`ifdef LEAF_OUT_CREDIT_EN
   localparam int CrInit = 2;
`else
   localparam int CrInit = 64;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic [N*P-1:0]    din;
   logic [N-1:0]      vld, ack;
   logic [N*(L+PT)-1:0] dest_cfg;
   logic              credit_ret_vld;
   logic [PT-1:0]     credit_ret_port;
   logic [CB-1:0]     credit_ret_amt;
   logic              bft_rdy, resend;
   logic [PB-1:0]     dout;

   int                checks = 0;
   int                errors = 0;
   int                n_popped = 0;
   logic [PB-1:0]     exp_q [$];
   logic [A-1:0]      exp_seq [N];
   logic [PB-1:0]     pkt_s;
   logic [N-1:0]      exp_ack;
   int                cnt [N];

   leaf_out_arbiter #(
      .PAYLOAD_BITS  (P),
      .NUM_LEAF_BITS (L),
      .NUM_PORT_BITS (PT),
      .NUM_ADDR_BITS (A),
      .NUM_OUT_PORTS (N),
      .CREDIT_BITS   (CB),
      .CREDIT_INIT   (CrInit)
   ) dut (
      .clk                     (clk),
      .reset                   (reset),
      .din_leaf_user2interface (din),
      .vld_user2interface      (vld),
      .ack_interface2user      (ack),
      .dest_cfg                (dest_cfg),
      .credit_ret_vld          (credit_ret_vld),
      .credit_ret_port         (credit_ret_port),
      .credit_ret_amt          (credit_ret_amt),
      .bft_rdy                 (bft_rdy),
      .resend                  (resend),
      .dout_leaf_interface2bft (dout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input int i, input logic [P-1:0] pay, output logic [PB-1:0] pkt);
      pkt = {1'b1, L'(3 + i), PT'(2 + i), exp_seq[i], pay};
      exp_seq[i] = exp_seq[i] + 1'b1;
      exp_q.push_back(pkt);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         tick();
         n++;
      end
      check(tag, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic clear_model();
      exp_q.delete();
      for (int i = 0; i < N; i++) exp_seq[i] = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      vld   = '0;
      clear_model();
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   // Scoreboard side: every valid packet must be the next expected one.
   always @(negedge clk) begin
      if (!reset && dout[PB-1]) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pkt", 64'(dout), 64'd0);
         end else begin
            check("pkt", 64'(dout), 64'(exp_q.pop_front()));
            n_popped++;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset           = 1'b1;
      vld             = '1;
      din             = {N{32'hCAFE_F00D}};
      bft_rdy         = 1'b1;
      resend          = 1'b0;
      credit_ret_vld  = 1'b0;
      credit_ret_port = '0;
      credit_ret_amt  = '0;
      for (int i = 0; i < N; i++) dest_cfg[i*(L+PT) +: (L+PT)] = {L'(3 + i), PT'(2 + i)};
      clear_model();

      // Reset state: all holds empty, nothing captured, dout idle.
      tick();
      tick();
      check("reset_ack", 64'(ack), 64'({N{1'b1}}));
      check("reset_dout", 64'(dout), 64'd0);
      vld   = '0;
      reset = 1'b0;
      tick();
      check("post_reset_dout", 64'(dout), 64'd0);
      check("post_reset_ack", 64'(ack), 64'({N{1'b1}}));

      // Single send on port 0 with two-edge latency, then seq advances.
      din[0 +: P] = 32'hDEAD_BEEF;
      vld[0]      = 1'b1;
      check("t2_ack", 64'(ack[0]), 64'd1);
      push_exp(0, 32'hDEAD_BEEF, pkt_s);
      tick();
      vld[0] = 1'b0;
      check("t2_lat_edge1", 64'(dout), 64'd0);
      tick();
      check("t2_lat_edge2", 64'(dout), 64'({1'b1, 5'd3, 4'd2, 7'd0, 32'hDEAD_BEEF}));
      din[0 +: P] = 32'h1234_5678;
      vld[0]      = 1'b1;
      push_exp(0, 32'h1234_5678, pkt_s);
      tick();
      vld[0] = 1'b0;
      tick();
      check("t2_seq1", 64'(dout[P +: A]), 64'd1);
      drain("t2_drain");

      // All ports streaming: grants rotate 0..4, ack only on the granted port.
      do_reset();
`ifdef LEAF_OUT_CREDIT_EN
      for (int p = 0; p < N; p++) begin
         credit_ret_vld  = 1'b1;
         credit_ret_port = PT'(p);
         credit_ret_amt  = 8'd200;
         tick();
      end
      credit_ret_vld = 1'b0;
`endif
      for (int k = 0; k < 16; k++) push_exp(k % N, {8'(k % N), 24'(k / N)}, pkt_s);
      for (int i = 0; i < N; i++) cnt[i] = 0;
      vld = '1;
      for (int c = 0; c < 12; c++) begin
         for (int i = 0; i < N; i++) din[i*P +: P] = {8'(i), 24'(cnt[i])};
         exp_ack = (c == 0) ? {N{1'b1}} : (N'(1) << ((c - 1) % N));
         check("t3_ack", 64'(ack), 64'(exp_ack));
         for (int i = 0; i < N; i++) if (exp_ack[i]) cnt[i]++;
         tick();
      end
      vld = '0;
      drain("t3_drain");

      // Resend holds everything; pending ports then go out in round-robin order.
      resend = 1'b1;
      vld    = 5'b10101;
      for (int i = 0; i < N; i++) din[i*P +: P] = 32'hA000_0000 + 32'(i);
      tick();
      vld = '0;
      for (int c = 0; c < 3; c++) begin
         check("t4_resend_dout", 64'(dout), 64'd0);
         check("t4_resend_ack", 64'(ack), 64'(5'b01010));
         tick();
      end
      resend  = 1'b0;
      bft_rdy = 1'b0;
      tick();
      check("t4_notrdy_dout", 64'(dout), 64'd0);
      push_exp(2, 32'hA000_0002, pkt_s);
      push_exp(4, 32'hA000_0004, pkt_s);
      push_exp(0, 32'hA000_0000, pkt_s);
      bft_rdy = 1'b1;
      drain("t4_drain");

      // Long stream on port 0 covering the seq wrap, then reset mid-stream.
      do_reset();
`ifdef LEAF_OUT_CREDIT_EN
      credit_ret_vld  = 1'b1;
      credit_ret_port = '0;
      credit_ret_amt  = 8'd200;
      tick();
      credit_ret_vld = 1'b0;
`endif
      n_popped = 0;
      vld[0]   = 1'b1;
      for (int k = 0; k < 133; k++) begin
         din[0 +: P] = 32'h5000 + 32'(k);
         push_exp(0, 32'h5000 + 32'(k), pkt_s);
         tick();
      end
      #2;
      reset = 1'b1;
      #1;
      check("t5_rst_dout", 64'(dout), 64'd0);
      check("t5_rst_ack", 64'(ack), 64'({N{1'b1}}));
      check("t5_popped", 64'(n_popped), 64'd131);
      clear_model();
      tick();
      vld   = '0;
      reset = 1'b0;
      tick();
      check("t5_no_capture_dout", 64'(dout), 64'd0);
      check("t5_no_capture_ack", 64'(ack), 64'({N{1'b1}}));

      // Port 1 streaming after reset; with credits only CREDIT_INIT packets go before a return.
      push_exp(1, 32'hB000, pkt_s);
      push_exp(1, 32'hB001, pkt_s);
`ifndef LEAF_OUT_CREDIT_EN
      push_exp(1, 32'hB002, pkt_s);
`endif
      vld[1] = 1'b1;
      for (int j = 0; j < 3; j++) begin
         din[P +: P] = 32'hB000 + 32'(j);
         check("t6_ack_stream", 64'(ack[1]), 64'd1);
         tick();
      end
      vld[1] = 1'b0;
`ifdef LEAF_OUT_CREDIT_EN
      check("t6_ack_blocked", 64'(ack[1]), 64'd0);
      drain("t6_drain_credit");
      credit_ret_vld  = 1'b1;
      credit_ret_port = 4'd9;
      credit_ret_amt  = 8'd5;
      tick();
      credit_ret_vld = 1'b0;
      tick();
      tick();
      check("t6_bad_port_ignored", 64'(ack[1]), 64'd0);
      push_exp(1, 32'hB002, pkt_s);
      credit_ret_vld  = 1'b1;
      credit_ret_port = 4'd1;
      credit_ret_amt  = 8'd1;
      tick();
      credit_ret_vld = 1'b0;
`else
      check("t6_ack_open", 64'(ack[1]), 64'd1);
`endif
      drain("t6_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
